// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between a CPU and a DMA/loader port.
// DMA has priority in bounded bursts, with one forced CPU cycle between bursts and ROM write protection.
module mem_arbiter #(
    parameter logic [15:0]  ROM_BASE  = 16'hF000,
    parameter int unsigned  MAX_BURST = 4
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        rom_sel,
    output logic        rom_wr_err,
    output logic [15:0] dma_xfer_cnt
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DMA  = 2'd1,
        ST_FAIR = 2'd2
    } state_t;

    state_t             r_state;
    logic [BURST_W-1:0] r_burst;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic               r_rom_wr_err;

    state_t             w_nxt_state;
    logic [BURST_W-1:0] w_nxt_burst;
    logic [BURST_W-1:0] w_burst_inc;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_nxt_err;
    logic               w_owner_dma;
    bus_req_t           w_cpu_bus;
    bus_req_t           w_dma_bus;
    bus_req_t           w_own_bus;
    logic               w_rom_hit;
    logic               w_wr_blocked;

    assign w_cpu_bus   = '{req: cpu_req, addr: cpu_addr, we: cpu_we, wdata: cpu_wdata};
    assign w_dma_bus   = '{req: dma_req, addr: dma_addr, we: dma_we, wdata: dma_wdata};
    assign w_owner_dma = (r_state == ST_DMA);
    assign w_own_bus   = w_owner_dma ? w_dma_bus : w_cpu_bus;
    assign w_rom_hit   = (w_own_bus.addr >= ROM_BASE);
    assign w_burst_inc = r_burst + BURST_W'(1);

    // Next-state, counters and combinational bus outputs
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_burst  = r_burst;
        w_nxt_cnt    = r_xfer_cnt;
        w_nxt_err    = r_rom_wr_err;
        w_wr_blocked = 1'b0;
        mem_addr     = w_own_bus.addr;
        mem_wdata    = w_own_bus.wdata;
        mem_we       = 1'b0;
        cpu_rdy      = 1'b0;
        dma_gnt      = 1'b0;

        if (!reset) begin
            cpu_rdy      = !w_owner_dma && cpu_req;
            dma_gnt      = w_owner_dma;
            mem_we       = w_own_bus.req && w_own_bus.we && !w_rom_hit;
            w_wr_blocked = w_own_bus.req && w_own_bus.we && w_rom_hit;
        end

        unique case (r_state)
            ST_CPU: begin
                if (dma_req) begin
                    w_nxt_state = ST_DMA;
                    w_nxt_burst = '0;
                end
            end
            ST_DMA: begin
                if (dma_req) begin
                    w_nxt_cnt = r_xfer_cnt + CNT_W'(1);
                    if (w_burst_inc == BURST_W'(MAX_BURST)) begin
                        // Burst exhausted: yield one cycle only if the CPU is waiting
                        w_nxt_burst = '0;
                        w_nxt_state = cpu_req ? ST_FAIR : ST_DMA;
                    end else begin
                        w_nxt_burst = w_burst_inc;
                    end
                end else begin
                    w_nxt_state = ST_CPU;
                end
            end
            ST_FAIR: begin
                w_nxt_burst = '0;
                w_nxt_state = dma_req ? ST_DMA : ST_CPU;
            end
            default: begin
                w_nxt_state = ST_CPU;
                w_nxt_burst = '0;
            end
        endcase

        if (w_wr_blocked) begin
            w_nxt_err = 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= ST_CPU;
            r_burst      <= '0;
            r_xfer_cnt   <= '0;
            r_rom_wr_err <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_burst      <= w_nxt_burst;
            r_xfer_cnt   <= w_nxt_cnt;
            r_rom_wr_err <= w_nxt_err;
        end
    end

    assign rom_sel      = (mem_addr >= ROM_BASE);
    assign cpu_rdata    = mem_rdata;
    assign dma_rdata    = mem_rdata;
    assign rom_wr_err   = r_rom_wr_err;
    assign dma_xfer_cnt = r_xfer_cnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ROM_BASE, 16'hF000, lowest ROM address; ROM spans ROM_BASE..16'hFFFF, including reset vector 16'hFFFC/FFFD.
REQ-002 Parameter: MAX_BURST, 4, maximum consecutive DMA transfers before one forced CPU cycle (legal 1..15).
REQ-003 Single clock ph1, reset synchronous and active-high on reset; all state changes on rising ph1.
REQ-004 ph1  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cpu_req  in  1  CPU requests a bus cycle.
REQ-007 cpu_addr  in  16 / cpu_we  in  1 / cpu_wdata  in  8  CPU address, write enable, write data.
REQ-008 cpu_rdy  out  1  CPU cycle completes this cycle; CPU stalls while low.
REQ-009 dma_req  in  1  DMA/loader requests a bus cycle.
REQ-010 dma_addr  in  16 / dma_we  in  1 / dma_wdata  in  8  DMA address, write enable, write data.
REQ-011 dma_gnt  out  1  DMA owns bus; transfer occurs when dma_gnt and dma_req both high.
REQ-012 mem_addr  out  16 / mem_we  out  1 / mem_wdata  out  8  shared memory port.
REQ-013 mem_rdata  in  8  memory read data, combinational from mem_addr.
REQ-014 cpu_rdata  out  8 / dma_rdata  out  8  both equal mem_rdata; valid only when cpu_rdy or dma_gnt respectively.
REQ-015 rom_sel  out  1  high when mem_addr >= ROM_BASE.
REQ-016 rom_wr_err  out  1  sticky flag: a write to ROM was blocked.
REQ-017 dma_xfer_cnt  out  16  count of completed DMA transfers.

Function
REQ-018 State register with states CPU, DMA, FAIR; owner = DMA in DMA state, CPU otherwise.
REQ-019 mem_addr/mem_we/mem_wdata SHALL mux from owner's inputs combinationally.
REQ-020 In CPU or FAIR: cpu_rdy = cpu_req, dma_gnt = 0; in DMA: cpu_rdy = 0, dma_gnt = 1.
REQ-021 CPU -> DMA at edge when dma_req high (DMA priority); burst count cleared; grant latency exactly one cycle after dma_req first sampled.
REQ-022 CPU state with dma_req low: stay CPU.
REQ-023 DMA state, dma_req high: transfer; burst count +1; dma_xfer_cnt +1 (wraps FFFF -> 0000).
REQ-024 DMA state, dma_req low: no transfer, no count change; -> CPU next edge.
REQ-025 When a transfer makes burst count equal MAX_BURST: -> FAIR if cpu_req high, else stay DMA with burst count cleared.
REQ-026 FAIR lasts exactly one cycle: -> DMA (burst cleared) if dma_req high, else -> CPU.
REQ-027 ROM protect: if owner's we high and owner's addr >= ROM_BASE, mem_we SHALL be 0; rom_wr_err set at that edge; the cycle still completes (cpu_rdy/dma transfer counted).
REQ-028 rom_wr_err clears only on reset.
REQ-029 mem_we SHALL be 0 whenever the owner's req is low.
REQ-030 Simultaneous cpu_req and dma_req in CPU state: CPU cycle completes this cycle (cpu_rdy=1), DMA granted next cycle.

Reset
REQ-031 While reset high at an edge: state <= CPU, burst count <= 0, dma_xfer_cnt <= 0, rom_wr_err <= 0.
REQ-032 While reset high: cpu_rdy = 0, dma_gnt = 0, mem_we = 0 (combinational override).
REQ-033 Reset mid-burst aborts DMA; first cycle after reset is CPU state; no transfer counted in the reset cycle.

Verification
REQ-034 Reset then cpu_req=1, cpu_addr=16'hFFFC, cpu_we=0 -> cpu_rdy=1, mem_addr=16'hFFFC, rom_sel=1, cpu_rdata=mem_rdata.
REQ-035 cpu_req=1 steady, dma_req=1 for 10 cycles, MAX_BURST=4 -> dma_gnt pattern 0,1,1,1,1,0,1,1,1,1,0; cpu_rdy high exactly in gnt-low cycles; dma_xfer_cnt=8 after the window.
REQ-036 DMA write addr 16'h00A9 data 8'hAA -> mem_we=1, mem_wdata=8'hAA, rom_wr_err=0.
REQ-037 CPU write addr 16'hF010 -> mem_we=0, cpu_rdy=1, rom_wr_err=1 next cycle and held until reset.
REQ-038 Reset asserted during 3rd burst transfer -> next cycle dma_gnt=0, dma_xfer_cnt=0, state CPU; dma_req still high -> dma_gnt=1 one cycle after reset release.
REQ-039 dma_xfer_cnt preloaded via 65535 transfers plus one more -> reads 16'h0000.
